mpu_matrix_store: RTL



---
 rtl/mpu_pkg.sv | 44 ++++
 rtl/mpu_store_fifo.sv | 46 ++++
 rtl/mpu_matrix_store.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU types and sizes for the store engine.
// Optional macro MPU_STORE_ROW_END_EN adds a row_end flag to each buffered element.
package mpu_pkg;

    localparam int FP               = 32;
    localparam int M                = 3;
    localparam int N                = 3;
    localparam int MATRIX_REGISTERS = 16;
    localparam int BUF_DEPTH        = 2;

    localparam int MATRIX_REG_BITS  = $clog2(MATRIX_REGISTERS);
    localparam int MBITS            = $clog2(M);
    localparam int NBITS            = $clog2(N);
    localparam int ADDR_W           = MATRIX_REG_BITS + 1;
    localparam int ROW_W            = MBITS + 1;
    localparam int COL_W            = NBITS + 1;

    typedef enum logic {
        STORE_IDLE,
        STORE_MATRIX
    } store_state_t;

    typedef logic [FP-1:0] mpu_elem_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  m;
        logic [COL_W-1:0]  n;
    } store_req_t;

    typedef struct packed {
        mpu_elem_t data;
        logic      last;
`ifdef MPU_STORE_ROW_END_EN
        logic      row_end;
`endif
    } store_entry_t;

    // Zero or oversized dimensions are rejected before any read is issued.
    function automatic logic dims_legal(input logic [ROW_W-1:0] m, input logic [COL_W-1:0] n);
        return (m != '0) && (m <= ROW_W'(M)) && (n != '0) && (n <= COL_W'(N));
    endfunction

endpackage

// File: rtl/mpu_store_fifo.sv
// Two-entry output buffer for the store engine; entry layout depends on
// MPU_STORE_ROW_END_EN through store_entry_t.
module mpu_store_fifo
    import mpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  store_entry_t push_entry_i,
    input  logic         pop_i,
    output store_entry_t head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    store_entry_t mem_q [BUF_DEPTH];
    // One-bit pointers are enough because the depth is fixed at two.
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mpu_matrix_store.sv
// MPU store engine: reads an m x n matrix register row-major and streams it out.
// Optional macro MPU_STORE_ROW_END_EN adds elem_row_end_out.
module mpu_matrix_store
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              store_req_in,
    output logic              store_ready_out,
    input  logic [ADDR_W-1:0] reg_addr_in,
    input  logic [ROW_W-1:0]  m_in,
    input  logic [COL_W-1:0]  n_in,
    output logic              rf_rd_en_out,
    output logic [ADDR_W-1:0] rf_rd_addr_out,
    output logic [ROW_W-1:0]  rf_rd_row_out,
    output logic [COL_W-1:0]  rf_rd_col_out,
    input  logic [FP-1:0]     rf_rd_data_in,
    output logic              elem_valid_out,
    input  logic              elem_ready_in,
    output logic [FP-1:0]     elem_data_out,
    output logic              elem_last_out,
`ifdef MPU_STORE_ROW_END_EN
    output logic              elem_row_end_out,
`endif
    output logic              store_done_out,
    output logic              store_err_out
);

    store_state_t     state_q;
    store_req_t       req_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             issued_all_q;
    logic             rd_vld_q;
    logic             rd_last_q;
`ifdef MPU_STORE_ROW_END_EN
    logic             rd_row_end_q;
`endif
    logic             done_q;
    logic             err_q;

    logic             pop;
    logic             last_col;
    logic             last_row;
    logic             rd_en;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    store_entry_t     push_entry;
    store_entry_t     head;

    // A pop in this cycle frees a slot in time for a read issued now, which
    // keeps full-rate streaming bubble-free while never overflowing the buffer.
    always_comb begin
        pop        = elem_valid_out && elem_ready_in;
        last_col   = (col_q == req_q.n - COL_W'(1));
        last_row   = (row_q == req_q.m - ROW_W'(1));
        occupancy  = {1'b0, fifo_count} + {2'b00, rd_vld_q} - {2'b00, pop};
        rd_en      = (state_q == STORE_MATRIX) && !issued_all_q && (occupancy < 3'd2);
        push_entry = '0;
        push_entry.data = rf_rd_data_in;
        push_entry.last = rd_last_q;
`ifdef MPU_STORE_ROW_END_EN
        push_entry.row_end = rd_row_end_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STORE_IDLE;
            req_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            issued_all_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
`ifdef MPU_STORE_ROW_END_EN
            rd_row_end_q <= 1'b0;
`endif
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en && last_row && last_col;
`ifdef MPU_STORE_ROW_END_EN
            rd_row_end_q <= rd_en && last_col;
`endif
            case (state_q)
                STORE_IDLE: begin
                    if (store_req_in) begin
                        req_q        <= '{addr: reg_addr_in, m: m_in, n: n_in};
                        row_q        <= '0;
                        col_q        <= '0;
                        issued_all_q <= 1'b0;
                        if (dims_legal(m_in, n_in)) begin
                            state_q <= STORE_MATRIX;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                STORE_MATRIX: begin
                    if (rd_en) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                issued_all_q <= 1'b1;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                    if (pop && elem_last_out) begin
                        done_q  <= 1'b1;
                        state_q <= STORE_IDLE;
                    end
                end
                default: state_q <= STORE_IDLE;
            endcase
        end
    end

    mpu_store_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rd_vld_q),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .valid_o      (elem_valid_out),
        .count_o      (fifo_count)
    );

    assign store_ready_out = (state_q == STORE_IDLE);
    assign rf_rd_en_out    = rd_en;
    assign rf_rd_addr_out  = req_q.addr;
    assign rf_rd_row_out   = row_q;
    assign rf_rd_col_out   = col_q;
    assign elem_data_out   = head.data;
    assign elem_last_out   = head.last;
`ifdef MPU_STORE_ROW_END_EN
    assign elem_row_end_out = head.row_end;
`endif
    assign store_done_out  = done_q;
    assign store_err_out   = err_q;

endmodule
